// File: rtl/time_entry_loader_pkg.sv
// Shared constants and types for the keypad-to-BCD-timer entry loader.
package time_entry_loader_pkg;

    localparam int unsigned NDIGITS = 4;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned LCNT_W  = 4;

    localparam logic [DIGIT_W-1:0] KEY_DIGIT_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MAX_SEC_TENS = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_t;
        logic [DIGIT_W-1:0] min_u;
        logic [DIGIT_W-1:0] sec_t;
        logic [DIGIT_W-1:0] sec_u;
    } bcd_buf_t;

    // An entry may be loaded only if it is a legal MM:SS time and not 00:00.
    function automatic logic entry_is_valid(input bcd_buf_t b);
        return (b.sec_t <= BCD_MAX_SEC_TENS) && (b.sec_u <= BCD_MAX_UNITS) && (b != '0);
    endfunction

endpackage

// File: rtl/time_entry_loader_bcd_entry_shift4.sv
// Four-digit BCD entry buffer: digits enter at sec_u and shift towards min_t.
module bcd_entry_shift4
    import time_entry_loader_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               i_clear,
    input  logic               i_shift_en,
    input  logic [DIGIT_W-1:0] i_digit,
    output bcd_buf_t           o_buf,
    output logic [CNT_W-1:0]   o_count
);

    bcd_buf_t         r_buf;
    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = (r_count == CNT_W'(NDIGITS));

    // Once full, further digits are dropped rather than pushing min_t out.
    always_ff @(posedge clk) begin
        if (clr || i_clear) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (i_shift_en && !w_full) begin
            r_buf   <= '{min_t: r_buf.min_u, min_u: r_buf.sec_t,
                         sec_t: r_buf.sec_u, sec_u: i_digit};
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_buf   = r_buf;
    assign o_count = r_count;

endmodule

// File: rtl/time_entry_loader.sv
// Collects keypad digits into an MM:SS buffer and parallel-loads the BCD timer on commit.
module time_entry_loader
    import time_entry_loader_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_clear,
    input  logic               commit,
    input  logic               busy,
    output logic [DIGIT_W-1:0] data_sec_u,
    output logic [DIGIT_W-1:0] data_sec_t,
    output logic [DIGIT_W-1:0] data_min_u,
    output logic [DIGIT_W-1:0] data_min_t,
    output logic               loadn,
    output logic               entry_active,
    output logic [CNT_W-1:0]   digit_count,
    output logic               load_done,
    output logic               err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LCNT_W-1:0] r_load_cnt;

    logic     w_is_digit;
    logic     w_commit_ok;
    logic     w_entry_ok;
    logic     w_shift_en;
    logic     w_buf_clear;
    logic     w_loadn_nxt;
    logic     w_entry_active_nxt;
    logic     w_load_done_nxt;
    logic     w_err_nxt;
    bcd_buf_t w_buf;
    logic [CNT_W-1:0] w_count;

    logic r_loadn;
    logic r_entry_active;
    logic r_load_done;
    logic r_err;

    assign w_is_digit  = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign w_commit_ok = commit && !busy && !key_clear && (r_state == ENTRY);
    assign w_entry_ok  = entry_is_valid(w_buf);

    // State register and load-window counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_load_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_cnt <= (r_state == LOAD) ? r_load_cnt + LCNT_W'(1) : '0;
        end
    end

    // Next-state logic; key_clear outranks digits and commit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!key_clear && w_is_digit && !busy)
                    w_state_nxt = ENTRY;
            end
            ENTRY: begin
                if (key_clear)
                    w_state_nxt = IDLE;
                else if (w_commit_ok && w_entry_ok)
                    w_state_nxt = LOAD;
            end
            LOAD: begin
                if (r_load_cnt == LCNT_W'(LOAD_CYCLES - 1))
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Buffer control and next values of the registered outputs.
    always_comb begin
        w_shift_en  = 1'b0;
        w_buf_clear = 1'b0;
        case (r_state)
            IDLE, ENTRY: begin
                if (key_clear)
                    w_buf_clear = 1'b1;
                else if (w_is_digit && !busy && !(commit && r_state == ENTRY))
                    w_shift_en = 1'b1;
            end
            DONE:    w_buf_clear = 1'b1;
            default: ;
        endcase
        w_loadn_nxt        = (w_state_nxt != LOAD);
        w_entry_active_nxt = (w_state_nxt == ENTRY);
        w_load_done_nxt    = (w_state_nxt == DONE);
        w_err_nxt          = w_commit_ok && !w_entry_ok;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_loadn        <= 1'b1;
            r_entry_active <= 1'b0;
            r_load_done    <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_loadn        <= w_loadn_nxt;
            r_entry_active <= w_entry_active_nxt;
            r_load_done    <= w_load_done_nxt;
            r_err          <= w_err_nxt;
        end
    end

    bcd_entry_shift4 u_shift (
        .clk        (clk),
        .clr        (clr),
        .i_clear    (w_buf_clear),
        .i_shift_en (w_shift_en),
        .i_digit    (key_code),
        .o_buf      (w_buf),
        .o_count    (w_count)
    );

    assign data_min_t   = w_buf.min_t;
    assign data_min_u   = w_buf.min_u;
    assign data_sec_t   = w_buf.sec_t;
    assign data_sec_u   = w_buf.sec_u;
    assign digit_count  = w_count;
    assign loadn        = r_loadn;
    assign entry_active = r_entry_active;
    assign load_done    = r_load_done;
    assign err          = r_err;

endmodule
